// File: rtl/period_meter_pkg.sv
// Shared state encoding and constants for the period meter and its averaging stage.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam int PERIOD_W_DEF = 16;
  localparam int PER_MAX      = (1 << PERIOD_W_DEF) - 1;

  localparam int AVG_N  = 4;
  localparam int AVG_SH = 2;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Two-flop synchroniser, delay flop and registered rising-edge pulse.
// Pin edge to o_rise is 3 clk; no backpressure, one pulse per synchronised rising edge.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_dly;
  logic r_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
      r_rise  <= r_sync2 & ~r_dly;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/period_meter.sv
// Measures sig_in period in prescaled ticks; result 1 clk after the detected edge (4 clk from pin).
// Optional PERIOD_AVG4_EN publishes the mean of the last four captures instead of the raw value.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int TICK_DIV   = 25,
  parameter int PERIOD_W   = PERIOD_W_DEF,
  parameter int MIN_PERIOD = 2,
  parameter int RST_PERIOD = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sig_in,
  output logic [PERIOD_W-1:0] binary,
  output logic                valid,
  output logic                over
);

  localparam int                  TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PERIOD_W-1:0] W_MAX = '1;

  state_t              r_state;
  logic [TW-1:0]       r_tick_cnt;
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [PERIOD_W-1:0] r_bin;
  logic                r_valid;
  logic                r_over;

  logic                w_rise;
  logic                w_tick;
  logic [PERIOD_W-1:0] w_cand;
  logic                w_in_meas;
  logic                w_cap;
  logic                w_sat;
  logic [PERIOD_W-1:0] w_bin_nxt;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst),
    .i_din  (sig_in),
    .o_rise (w_rise)
  );

  assign w_tick = en && (r_tick_cnt == TW'(TICK_DIV - 1));

  // A tick landing on the edge cycle still belongs to the interval being closed.
  assign w_cand    = (r_per_cnt == W_MAX) ? W_MAX
                   : r_per_cnt + {{(PERIOD_W-1){1'b0}}, w_tick};
  assign w_in_meas = en && (r_state == MEASURE);
  assign w_cap     = w_in_meas && w_rise && (w_cand >= PERIOD_W'(MIN_PERIOD));
  assign w_sat     = w_in_meas && !w_cap && (w_cand == W_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (!en || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

`ifdef PERIOD_AVG4_EN
  localparam int SW = PERIOD_W + AVG_SH;

  logic [PERIOD_W-1:0] r_hist [AVG_N];
  logic [2:0]          r_navg;
  logic [SW-1:0]       r_sum;
  logic [PERIOD_W-1:0] w_old;
  logic [SW-1:0]       w_sum_nxt;
  logic                w_avg_clr;

  assign w_old     = (r_navg == 3'(AVG_N)) ? r_hist[AVG_N-1] : '0;
  assign w_sum_nxt = r_sum + SW'(w_cand) - SW'(w_old);
  assign w_bin_nxt = (r_navg >= 3'(AVG_N - 1)) ? w_sum_nxt[SW-1:AVG_SH] : w_cand;
  assign w_avg_clr = !en || w_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < AVG_N; i++) r_hist[i] <= '0;
      r_navg <= '0;
      r_sum  <= '0;
    end else if (w_avg_clr) begin
      for (int i = 0; i < AVG_N; i++) r_hist[i] <= '0;
      r_navg <= '0;
      r_sum  <= '0;
    end else if (w_cap) begin
      r_hist[0] <= w_cand;
      for (int i = 1; i < AVG_N; i++) r_hist[i] <= r_hist[i-1];
      if (r_navg != 3'(AVG_N)) r_navg <= r_navg + 3'd1;
      r_sum <= w_sum_nxt;
    end
  end
`else
  assign w_bin_nxt = w_cand;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_per_cnt <= '0;
      r_bin     <= PERIOD_W'(RST_PERIOD);
      r_valid   <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_valid <= w_cap;
      if (!en) begin
        r_state   <= IDLE;
        r_per_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_per_cnt <= '0;
            if (w_rise) r_state <= MEASURE;
          end
          MEASURE: begin
            if (w_cap) begin
              r_bin     <= w_bin_nxt;
              r_per_cnt <= '0;
            end else begin
              r_per_cnt <= w_cand;
              if (w_sat) begin
                r_state <= TIMEOUT;
                r_over  <= 1'b1;
              end
            end
          end
          TIMEOUT: begin
            if (w_rise) begin
              r_over    <= 1'b0;
              r_per_cnt <= '0;
              r_state   <= MEASURE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign binary = r_bin;
  assign valid  = r_valid;
  assign over   = r_over;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a short tick divider and narrow counter so timeout is reachable.
module tb_period_meter;

  localparam int TD   = 4;
  localparam int PW   = 12;
  localparam int MINP = 2;
  localparam int RSTP = 1000;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sig_in;
  logic [PW-1:0] binary;
  logic          valid;
  logic          over;

  int n_chk   = 0;
  int n_pass  = 0;
  int n_valid = 0;
  int v0;
  int per [4] = '{1000, 1000, 1000, 1004};
`ifdef PERIOD_AVG4_EN
  int exp_bin [4] = '{1000, 1000, 1000, 1001};
`else
  int exp_bin [4] = '{1000, 1000, 1000, 1004};
`endif

  period_meter #(
    .TICK_DIV   (TD),
    .PERIOD_W   (PW),
    .MIN_PERIOD (MINP),
    .RST_PERIOD (RSTP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sig_in (sig_in),
    .binary (binary),
    .valid  (valid),
    .over   (over)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (valid) n_valid <= n_valid + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rising pin edge, then 5 clk so the resulting valid pulse has been seen.
  task automatic rise5();
    sig_in = 1'b1;
    clks(5);
  endtask

  // Completes a square period of p ticks measured from the preceding rise5.
  task automatic rest(input int p);
    clks(p * TD / 2 - 5);
    sig_in = 1'b0;
    clks(p * TD / 2);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
    #5 rst = 1'b0;
    #2;
    check("rst_binary", binary, RSTP);
    check("rst_valid", valid, 0);
    check("rst_over", over, 0);
    clks(3);
    rst = 1'b1; en = 1'b1;
    clks(50);
    check("idle_no_valid", n_valid, 0);

    // Basic measurement and 4-clk latency from pin edge to valid.
    v0 = n_valid;
    rise5(); rest(500);
    check("first_rise_no_valid", n_valid - v0, 0);
    sig_in = 1'b1;
    clks(3); check("valid_lat3_low", valid, 0);
    clks(1); check("valid_lat4_high", valid, 1);
    check("period_500", binary, 500);
    clks(1); rest(500);
    v0 = n_valid;
    rise5();
    check("third_rise_one_valid", n_valid - v0, 1);
    check("period_500_again", binary, 500);

    // Asynchronous reset in the middle of a measurement.
    clks(200);
    rst = 1'b0;
    #2;
    check("midrst_binary", binary, RSTP);
    check("midrst_valid", valid, 0);
    check("midrst_over", over, 0);
    sig_in = 1'b0;
    clks(5); rst = 1'b1; clks(5);

    // Glitch one tick after a true edge is ignored and does not restart the count.
    rise5(); rest(250);
    v0 = n_valid;
    sig_in = 1'b1; clks(2); sig_in = 1'b0; clks(2); sig_in = 1'b1; clks(1);
    rest(250);
    rise5();
    check("glitch_valid_cnt", n_valid - v0, 2);
    check("glitch_period", binary, 250);

    // Timeout after a capture of 500.
    rest(500);
    rise5();
    check("pre_timeout_cap", binary, 500);
    v0 = n_valid;
    clks(995); sig_in = 1'b0;
    clks((PMAX - 1) * TD + 3 - 1000);
    check("over_not_yet", over, 0);
    clks(5);
    check("over_set", over, 1);
    check("timeout_binary_held", binary, 500);
    check("timeout_no_valid", n_valid - v0, 0);
    rise5();
    check("over_cleared", over, 0);
    check("recover_no_valid", n_valid - v0, 0);
    check("recover_binary_held", binary, 500);
    rest(300);
    rise5();
    check("recover_valid", n_valid - v0, 1);
    check("recover_period", binary, 300);

    // Disable mid-period, then restart from idle.
    clks(100);
    en = 1'b0;
    v0 = n_valid;
    sig_in = 1'b0; clks(200); sig_in = 1'b1; clks(200); sig_in = 1'b0; clks(100);
    check("dis_no_valid", n_valid - v0, 0);
    check("dis_binary_held", binary, 300);
    check("dis_over_held", over, 0);
    en = 1'b1; clks(10);
    rise5(); rest(400);
    check("reen_first_no_valid", n_valid - v0, 0);
    rise5();
    check("reen_second_valid", n_valid - v0, 1);
    check("reen_period", binary, 400);

    // Four captures from a fresh start: raw, or running mean when averaging is built in.
    clks(100);
    en = 1'b0; clks(5);
    sig_in = 1'b0; en = 1'b1; clks(10);
    v0 = n_valid;
    rise5(); rest(per[0]);
    for (int i = 0; i < 4; i++) begin
      rise5();
      check($sformatf("seq_cap%0d", i), binary, exp_bin[i]);
      if (i < 3) rest(per[i+1]);
    end
    check("seq_valid_cnt", n_valid - v0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
